ksa_wide_seq: RTL and testbench
===============================

Name: ksa_wide_seq

Overview:
Sequencer that performs WORDS*BITS-bit additions on the team's pipelined Kogge-Stone adder. The adder is BITS wide, registers its inputs and its outputs, and has a latency of 2 clocks. This block sits directly upstream and downstream of the adder. It accepts wide operands over a valid/ready handshake, issues them one BITS-wide word at a time (LSW first), and feeds each word's carry-out (s[BITS]) back as the next word's carry-in. It assembles the wide result and presents it over a valid/ready handshake.

Parameters:
BITS, 64, adder word width; must match the attached adder.
WORDS, 4, words per wide operand (>=2).
ADD_LAT, 2, clocks from operand presentation to valid adder sum; must match the adder (2 for input+output registered adder).

Ports:
clk  in  1  clock, all state on posedge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  wide operand valid.
in_ready  out  1  block can accept operands (high only in IDLE).
in_a  in  WORDS*BITS  operand A.
in_b  in  WORDS*BITS  operand B.
in_c  in  1  carry-in to word 0.
add_a  out  BITS  to adder a.
add_b  out  BITS  to adder b.
add_c  out  1  to adder c.
add_s  in  BITS+1  from adder s; bit BITS is the carry-out.
out_valid  out  1  wide result valid.
out_ready  in  1  consumer accepts result.
out_sum  out  WORDS*BITS+1  wide sum; MSB is the final carry-out.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, out_sum=0, add_a/add_b/add_c=0, word index=0, wait counter=0, carry=0. in_ready=1 as soon as IDLE.
- The adder has no reset. Correctness relies only on holding inputs stable for ADD_LAT clocks before sampling.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. If in_valid is high at the clock edge: capture in_a, in_b; carry<=in_c; idx<=0; cnt<=0; go to RUN. add_* are driven 0.
- RUN: in_ready=0. add_a=A[idx], add_b=B[idx], add_c=carry. These are held stable for the whole word slot. cnt increments each clock.
  - When cnt==ADD_LAT: sample add_s. result word idx <= add_s[BITS-1:0]; carry <= add_s[BITS]; cnt<=0.
  - If idx==WORDS-1: out_sum[WORDS*BITS] <= add_s[BITS] and go to DONE. Otherwise idx<=idx+1.
- Slot length is ADD_LAT+1 clocks per word.
- Accept at edge T puts out_valid high from the clock after edge T+WORDS*(ADD_LAT+1). Defaults: first out_valid cycle follows edge T+12, i.e. cycle T+13.
- DONE: out_valid=1; out_sum stable; add_* driven 0; in_ready=0. When out_ready is high at the edge: out_valid<=0 and go to IDLE.
  - A new operand is accepted no earlier than the following cycle; there is no same-cycle turnaround.
- out_sum retains its last value after handshake until the next result is written. It is only guaranteed while out_valid=1.
- in_valid is ignored outside IDLE. Operands are captured, so in_a/in_b may change after acceptance.
- Reset asserted mid-RUN or in DONE aborts immediately. No partial result is ever flagged valid.
- Arithmetic: out_sum == in_a + in_b + in_c, exact, width WORDS*BITS+1; wrap-free.

Optional Feature:
KSA_WIDE_SUB_EN.
- Defined: adds input port in_sub (1 bit), captured with the operands.
  - in_sub=1: add_b=~B[idx] for every word; word-0 carry-in forced to 1 (in_c ignored). Result = A-B mod 2^(WORDS*BITS).
  - out_sum MSB = 1 when A>=B (no borrow).
  - in_sub=0: identical to plain addition.
- Undefined: no in_sub port; addition only.

Test Plan:
(Bench uses the team's registered KSA adder, BITS=64, WORDS=4, ADD_LAT=2.)
1. in_a=2^256-1, in_b=1, in_c=0 accepted at edge T -> out_valid rises at cycle T+13; out_sum=2^256 (bit256=1, bits 255:0 all 0).
2. in_a=5, in_b=7, in_c=1 -> out_sum=13, bit256=0. Each word slot holds add_* stable for 3 clocks. add_c word0=1, words1-3 add_c=0.
3. in_a=2^128-1, in_b=1 -> carry ripples through words 0,1. out_sum=2^128. Check add_c=1 on word slots 1 and 2, and 0 on slot 3.
4. Back-pressure: out_ready=0 for 10 cycles after out_valid -> out_valid, out_sum hold, in_ready=0. Then out_ready=1 -> next cycle out_valid=0, in_ready=1. A second operand in_a=1, in_b=1 yields 2.
5. Async reset pulse during word slot 2 -> immediately out_valid=0, add_*=0, in_ready=1 after release. Next op in_a=3, in_b=4 -> 7, with correct latency of 13.
6. KSA_WIDE_SUB_EN, in_sub=1:
   - in_a=3, in_b=5 -> out_sum[255:0]=2^256-2, bit256=0.
   - in_a=5, in_b=3 -> out_sum=2 with bit256=1.

Source files
------------

// File: rtl/ksa_wide_seq.sv
// Wide-operand sequencer around the registered BITS-wide Kogge-Stone adder.
// Optional subtract mode when KSA_WIDE_SUB_EN is defined (adds port in_sub).
//
// state | meaning
// IDLE  | ready for a new wide operand pair; adder inputs parked at 0
// RUN   | one word slot per ADD_LAT+1 clocks, LSW first, carry fed back
// DONE  | wide result presented until the consumer takes it
module ksa_wide_seq #(
    parameter int BITS    = 64,
    parameter int WORDS   = 4,
    parameter int ADD_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
`ifdef KSA_WIDE_SUB_EN
    input  logic                   in_sub,
`endif
    input  logic [WORDS*BITS-1:0]  in_a,
    input  logic [WORDS*BITS-1:0]  in_b,
    input  logic                   in_c,
    output logic [BITS-1:0]        add_a,
    output logic [BITS-1:0]        add_b,
    output logic                   add_c,
    input  logic [BITS:0]          add_s,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORDS*BITS:0]    out_sum
);

    localparam int WB    = WORDS * BITS;
    localparam int IDX_W = (WORDS < 2) ? 1 : $clog2(WORDS);
    localparam int CNT_W = (ADD_LAT < 1) ? 1 : $clog2(ADD_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WB-1:0]      a_q, a_d;
    logic [WB-1:0]      b_q, b_d;
    logic [WB:0]        sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0]    b_word;
    logic               carry_in;

    // Operands shift down one word per slot, so the live word is always at the bottom.
`ifdef KSA_WIDE_SUB_EN
    logic sub_q, sub_d;

    assign b_word   = b_q[BITS-1:0] ^ {BITS{sub_q}};
    assign carry_in = in_sub | in_c;

    always_comb begin
        sub_d = sub_q;
        if (state_q == IDLE && in_valid) begin
            sub_d = in_sub;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
        end
    end
`else
    assign b_word   = b_q[BITS-1:0];
    assign carry_in = in_c;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        add_a   = '0;
        add_b   = '0;
        add_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = carry_in;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                add_a = a_q[BITS-1:0];
                add_b = b_word;
                add_c = carry_q;
                if (cnt_q == CNT_W'(ADD_LAT)) begin
                    // Result words enter at the top and end up in place after WORDS slots.
                    sum_d[WB-1:0] = {add_s[BITS-1:0], sum_q[WB-1:BITS]};
                    carry_d       = add_s[BITS];
                    cnt_d         = '0;
                    a_d           = a_q >> BITS;
                    b_d           = b_q >> BITS;
                    if (idx_q == IDX_W'(WORDS - 1)) begin
                        sum_d[WB] = add_s[BITS];
                        state_d   = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ksa_wide_seq.sv
// Self-checking bench for ksa_wide_seq with a behavioural 2-stage registered adder.
module tb_ksa_wide_seq;
    localparam int BITS    = 64;
    localparam int WORDS   = 4;
    localparam int ADD_LAT = 2;
    localparam int WB      = WORDS * BITS;
    localparam int SLOT    = ADD_LAT + 1;
    localparam int LAT     = WORDS * SLOT;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WB-1:0]     in_a = '0;
    logic [WB-1:0]     in_b = '0;
    logic              in_c = 1'b0;
    logic [BITS-1:0]   add_a, add_b;
    logic              add_c;
    logic [BITS:0]     add_s;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WB:0]       out_sum;
`ifdef KSA_WIDE_SUB_EN
    logic              in_sub = 1'b0;
`endif

    // Registered adder model: operands registered, sum registered.
    logic [BITS-1:0]   ar, br;
    logic              cr;
    always @(posedge clk) begin
        ar    <= add_a;
        br    <= add_b;
        cr    <= add_c;
        add_s <= {1'b0, ar} + {1'b0, br} + {{BITS{1'b0}}, cr};
    end

    ksa_wide_seq #(.BITS(BITS), .WORDS(WORDS), .ADD_LAT(ADD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
`ifdef KSA_WIDE_SUB_EN
        .in_sub(in_sub),
`endif
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_s(add_s),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [WB:0] got, input logic [WB:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [WB:0] model(input logic [WB-1:0] a, input logic [WB-1:0] b,
                                          input logic c, input logic sub);
        logic [WB-1:0] diff;
        if (sub) begin
            diff = a - b;
            return {(a >= b), diff};
        end
        return {1'b0, a} + {1'b0, b} + {{WB{1'b0}}, c};
    endfunction

    // Carry entering word k of the wide addition, from partial sums of the low k words.
    function automatic logic carry_into(input logic [WB-1:0] a, input logic [WB-1:0] b,
                                        input logic c, input logic sub, input int k);
        logic [WB-1:0] bb;
        logic [WB:0]   m, s;
        logic          cc;
        bb = sub ? ~b : b;
        cc = sub ? 1'b1 : c;
        if (k == 0) return cc;
        m = ({{WB{1'b0}}, 1'b1} << (BITS * k)) - 1'b1;
        s = ({1'b0, a} & m) + ({1'b0, bb} & m) + {{WB{1'b0}}, cc};
        return s[BITS * k];
    endfunction

    task automatic do_op(input logic [WB-1:0] a, input logic [WB-1:0] b, input logic c,
                         input logic sub, input int hold, input logic [WB:0] exp,
                         input string tag);
        int n;
        logic [BITS-1:0] ca [LAT];
        logic [BITS-1:0] cb [LAT];
        logic            cc [LAT];
        logic [BITS-1:0] ew;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_ready"}, {{WB{1'b0}}, in_ready}, {{WB{1'b0}}, 1'b1});
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_c = c;
`ifdef KSA_WIDE_SUB_EN
        in_sub = sub;
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = ~a;
        in_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        in_c = ~c;
`ifdef KSA_WIDE_SUB_EN
        in_sub = ~sub;
`endif
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid || n >= 40) break;
            if (n < LAT) begin
                ca[n] = add_a;
                cb[n] = add_b;
                cc[n] = add_c;
            end
            @(posedge clk);
            n++;
        end
        chk({tag, "_latency"}, WB'(n), WB'(LAT));
        chk({tag, "_valid"}, {{WB{1'b0}}, out_valid}, {{WB{1'b0}}, 1'b1});
        for (int i = 0; i < LAT; i++) begin
            ew = sub ? ~b[(i / SLOT) * BITS +: BITS] : b[(i / SLOT) * BITS +: BITS];
            chk($sformatf("%s_slot%0d_cyc%0d", tag, i / SLOT, i % SLOT),
                {1'b0, 63'd0, ca[i], cb[i], cc[i]},
                {1'b0, 63'd0, a[(i / SLOT) * BITS +: BITS], ew, carry_into(a, b, c, sub, i / SLOT)});
        end
        chk({tag, "_sum"}, out_sum, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s_hold%0d_sum", tag, i), out_sum, exp);
            chk($sformatf("%s_hold%0d_flags", tag, i), {{(WB-1){1'b0}}, out_valid, in_ready},
                {{(WB-1){1'b0}}, 2'b10});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_release"}, {{(WB-1){1'b0}}, out_valid, in_ready}, {{(WB-1){1'b0}}, 2'b01});
    endtask

    typedef struct {
        logic [WB-1:0] a;
        logic [WB-1:0] b;
        logic          c;
        logic          sub;
        int            hold;
        logic [WB:0]   exp;
    } vec_t;

    function automatic vec_t mk(input logic [WB-1:0] a, input logic [WB-1:0] b, input logic c,
                                input logic sub, input int hold, input logic [WB:0] exp);
        vec_t v;
        v.a = a; v.b = b; v.c = c; v.sub = sub; v.hold = hold; v.exp = exp;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [WB-1:0] ra, rb;
        logic          rc, rs;
        logic [WB-1:0] one128;
        one128 = ({{(WB-1){1'b0}}, 1'b1} << 128) - 1'b1;

        tbl.push_back(mk('1, WB'(1), 1'b0, 1'b0, 0, {1'b1, {WB{1'b0}}}));
        tbl.push_back(mk(WB'(5), WB'(7), 1'b1, 1'b0, 0, (WB+1)'(13)));
        tbl.push_back(mk(one128, WB'(1), 1'b0, 1'b0, 0, (WB+1)'(one128) + 1'b1));
        tbl.push_back(mk(WB'(12), WB'(30), 1'b0, 1'b0, 10, (WB+1)'(42)));
        tbl.push_back(mk(WB'(1), WB'(1), 1'b0, 1'b0, 0, (WB+1)'(2)));
`ifdef KSA_WIDE_SUB_EN
        tbl.push_back(mk(WB'(3), WB'(5), 1'b0, 1'b1, 0, {1'b0, {(WB-1){1'b1}}, 1'b0}));
        tbl.push_back(mk(WB'(5), WB'(3), 1'b1, 1'b1, 0, {1'b1, WB'(2)}));
        tbl.push_back(mk(WB'(9), WB'(9), 1'b0, 1'b1, 0, {1'b1, WB'(0)}));
`endif

        #12;
        chk("reset_outputs", {{(WB-2*BITS-2){1'b0}}, out_valid, in_ready, add_a, add_b, add_c},
            {{(WB-2*BITS-2){1'b0}}, 1'b0, 1'b1, {BITS{1'b0}}, {BITS{1'b0}}, 1'b0});
        chk("reset_sum", out_sum, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i])
            do_op(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].sub, tbl[i].hold, tbl[i].exp,
                  $sformatf("vec%0d", i));

        // Abort in word slot 2 with an asynchronous reset pulse.
        in_valid = 1'b1;
        in_a = '1;
        in_b = '1;
        in_c = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {{(WB-2*BITS-2){1'b0}}, out_valid, in_ready, add_a, add_b, add_c},
            {{(WB-2*BITS-2){1'b0}}, 1'b0, 1'b1, {BITS{1'b0}}, {BITS{1'b0}}, 1'b0});
        chk("abort_sum", out_sum, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(WB'(3), WB'(4), 1'b0, 1'b0, 0, (WB+1)'(7), "after_abort");

        for (int i = 0; i < 8; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (i % 3 == 0) rb = ~ra;
            rc = 1'($urandom);
`ifdef KSA_WIDE_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            do_op(ra, rb, rc, rs, int'($urandom_range(0, 2)), model(ra, rb, rc, rs),
                  $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
